// File: rtl/zorro3_master_requester_if.sv
// Pin-side and engine-side signals of the Zorro III bus-mastership requester.
// slave modport faces the requester; master modport faces the engine/board model.
interface zorro3_master_requester_if;
  logic c7m_in;
  logic ebg_n_in;
  logic req;
  logic busy;
  logic granted;
  logic ebr_n_out;
  logic ebr_n_oe;
  logic reg_error;

  modport slave (
    input  c7m_in,
    input  ebg_n_in,
    input  req,
    input  busy,
    output granted,
    output ebr_n_out,
    output ebr_n_oe,
    output reg_error
  );

  modport master (
    output c7m_in,
    output ebg_n_in,
    output req,
    output busy,
    input  granted,
    input  ebr_n_out,
    input  ebr_n_oe,
    input  reg_error
  );
endinterface

// File: rtl/zorro3_master_requester.sv
// Requests/relinquishes Zorro III mastership via one-C7M-period EBR pulses and
// turns the synchronized EBG into a level grant; pulses always span rise-to-rise of C7M.
module zorro3_master_requester #(
  parameter int HOLDOFF_C7M = 4,
  parameter int SYNC_STAGES = 3
) (
  input  logic                        clk100,
  input  logic                        reset_n,
  zorro3_master_requester_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REG_PULSE,
    S_WAIT_GRANT,
    S_OWNED,
    S_DEREG_PULSE,
    S_RELEASE
  } state_t;

  localparam logic [3:0] HOLDOFF_LOAD = 4'(HOLDOFF_C7M);

  logic [SYNC_STAGES-1:0] r_c7m_sync;
  logic [SYNC_STAGES-1:0] r_ebg_sync;
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_ebr_n;
  logic                   w_ebr_n_nxt;
  logic                   r_reg_error;
  logic                   w_reg_error_nxt;
  logic                   r_oe;
  logic [3:0]             r_holdoff;
  logic                   w_holdoff_load;
  logic                   w_c7m_rise;
  logic                   w_c7m_fall;
  logic                   w_ebg_s;

  // Both inputs idle high, so the chains reset to 1 and no false edge appears.
  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      r_c7m_sync <= '1;
      r_ebg_sync <= '1;
    end else begin
      r_c7m_sync <= {r_c7m_sync[SYNC_STAGES-2:0], bus.c7m_in};
      r_ebg_sync <= {r_ebg_sync[SYNC_STAGES-2:0], bus.ebg_n_in};
    end
  end

  assign w_c7m_rise = r_c7m_sync[SYNC_STAGES-2] & ~r_c7m_sync[SYNC_STAGES-1];
  assign w_c7m_fall = ~r_c7m_sync[SYNC_STAGES-2] & r_c7m_sync[SYNC_STAGES-1];
  assign w_ebg_s    = r_ebg_sync[SYNC_STAGES-1];

  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_ebr_n     <= 1'b1;
      r_reg_error <= 1'b0;
      r_oe        <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ebr_n     <= w_ebr_n_nxt;
      r_reg_error <= w_reg_error_nxt;
      r_oe        <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_ebr_n_nxt     = r_ebr_n;
    w_reg_error_nxt = r_reg_error;
    w_holdoff_load  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.req && (r_holdoff == 4'd0) && w_c7m_rise) begin
          w_ebr_n_nxt = 1'b0;
          w_state_nxt = S_REG_PULSE;
        end
      end
      S_REG_PULSE: begin
        if (w_c7m_rise) begin
          w_ebr_n_nxt = 1'b1;
          w_state_nxt = S_WAIT_GRANT;
        end
      end
      S_WAIT_GRANT: begin
        // A grant arriving together with a withdrawal wins.
        if (!w_ebg_s) begin
          w_state_nxt = S_OWNED;
        end else if (!bus.req && w_c7m_rise) begin
          w_ebr_n_nxt = 1'b0;
          w_state_nxt = S_DEREG_PULSE;
        end
      end
      S_OWNED: begin
        if (w_ebg_s) begin
          w_reg_error_nxt = 1'b1;
          w_holdoff_load  = 1'b1;
          w_state_nxt     = S_IDLE;
        end else if (!bus.req && !bus.busy && w_c7m_rise) begin
          w_ebr_n_nxt = 1'b0;
          w_state_nxt = S_DEREG_PULSE;
        end
      end
      S_DEREG_PULSE: begin
        if (w_c7m_rise) begin
          w_ebr_n_nxt = 1'b1;
          w_state_nxt = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (w_ebg_s) begin
          w_holdoff_load = 1'b1;
          w_state_nxt    = S_IDLE;
        end
      end
      default: begin
        w_ebr_n_nxt = 1'b1;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Counts down in C7M periods and stops at zero.
  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      r_holdoff <= 4'd0;
    end else if (w_holdoff_load) begin
      r_holdoff <= HOLDOFF_LOAD;
    end else if (w_c7m_fall && (r_holdoff != 4'd0)) begin
      r_holdoff <= r_holdoff - 4'd1;
    end
  end

  // Qualified with the live EBG so a lost grant drops in the detection cycle.
  assign bus.granted   = (r_state == S_OWNED) && !w_ebg_s;
  assign bus.ebr_n_out = r_ebr_n;
  assign bus.ebr_n_oe  = r_oe;
  assign bus.reg_error = r_reg_error;

endmodule
